dspace_frame_rx: RTL and testbench
==================================

DSPACE_FRAME_RX -- requirements
Module: dspace_frame_rx

Interface
REQ-001 SHALL have clk  in  1  system clock; all logic on posedge clk.
REQ-002 SHALL have rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have sw  in  2  slot-rate select; latched at frame start.
REQ-004 SHALL have frame_start  in  1  single-cycle, already-synchronised start strobe; same event that restarts the upstream nibble transmitter.
REQ-005 SHALL have nib_in  in  4  upstream 4-bit slot bus, one nibble per slot.
REQ-006 SHALL have rx_w1, rx_w2, rx_w3  out  4 each  received low-word nibbles, slots 1-3.
REQ-007 SHALL have vhi1, vhi2, vhi3  out  4 each  received voltage high nibbles, slots 4-6.
REQ-008 SHALL have frame_valid  out  1  one-cycle pulse when a checked frame updates the outputs.
REQ-009 SHALL have frame_err  out  1  one-cycle pulse on a sync-nibble mismatch.
REQ-010 SHALL have busy  out  1  high from the cycle after frame_start until DONE or error.
REQ-011 SHALL have err_cnt  out  8  saturating error count; present only with DFRX_ERRCNT_EN.

Function
REQ-012 SHALL map RATE by sw: 0->500, 1->750, 2->1000, 3->1250 cycles; slot length = RATE+1 cycles.
REQ-013 SHALL use states IDLE, ALIGN, RECV, CHECK.
REQ-014 IDLE: on frame_start, latch RATE, clear slot index, go to ALIGN.
REQ-015 ALIGN SHALL count RATE+2 cycles after the frame_start cycle; slot 0 begins on the following cycle; go to RECV.
REQ-016 RECV SHALL sample nib_in once per slot, at offset RATE/2 (integer divide) from slot start, into capture register [slot index].
REQ-017 Frame layout SHALL be 9 slots: 0 = 4'b0000; 1-3 = rx_w1..3; 4-6 = vhi1..3; 7, 8 = 4'b1111.
REQ-018 After the slot-8 sample, SHALL go to CHECK on the next cycle; the 4'b0000/4'b1111 test applies only to slots 0, 7 and 8; data slots may hold any value.
REQ-019 CHECK pass: copy captures to outputs and pulse frame_valid on the same edge; fail: outputs hold and frame_err pulses; either way go to IDLE.
REQ-020 Output latency SHALL be exactly 1 cycle from the slot-8 sample edge.
REQ-021 frame_start in ALIGN, RECV or CHECK SHALL restart ALIGN (re-latch sw, clear captures, no error pulse).
REQ-022 sw changes after frame_start SHALL have no effect until the next frame_start.
REQ-023 frame_valid and frame_err SHALL never assert in the same cycle.
REQ-024 Slot counter SHALL wrap from RATE to 0 with no gap between slots.

Reset
REQ-025 rst SHALL force IDLE; set all data outputs to 4'h0, frame_valid/frame_err/busy to 0, err_cnt to 0, captures to 0.
REQ-026 rst has priority over frame_start in the same cycle; rst mid-frame drops the frame with no pulses.

Configuration
REQ-027 With DFRX_ERRCNT_EN defined: err_cnt increments on every frame_err and saturates at 255; cleared only by rst.
REQ-028 Without DFRX_ERRCNT_EN: err_cnt port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-029 Shared package dfrx_pkg SHALL hold state encoding, SYNC_W = 4'b0000, SYNC_F = 4'b1111, NUM_SLOTS = 9, and the sw->RATE table.
REQ-030 One sub-module dfrx_slot_timer SHALL provide the latched RATE, slot counter, slot index, and sample/slot-end strobes.

Verification
REQ-031 sw=1, frame_start, stream 0,3,5,9,A,B,C,F,F -> frame_valid once at sample-8 edge +1; rx_w=3,5,9; vhi=A,B,C.
REQ-032 sw=0, slot 7 = 4'hE -> frame_err pulse, outputs keep previous values, err_cnt +1 (macro on).
REQ-033 Second frame_start during slot 4 -> no error; the full frame after the restart decodes correctly.
REQ-034 rst asserted during slot 5 -> all outputs 0, IDLE, no pulses; next frame decodes normally.
REQ-035 sw toggled 3->0 mid-frame started with sw=3 -> samples stay at RATE=1250 spacing; frame valid.
REQ-036 260 consecutive bad frames (macro on) -> err_cnt=255 held; frame_err still pulses each frame.

Source files
------------

// File: rtl/dfrx_pkg.sv
// Shared types and constants for the dSPACE nibble-frame receiver:
// FSM encoding, sync nibbles, frame length and the sw -> RATE table.
package dfrx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_RECV,
        ST_CHECK
    } state_e;

    localparam logic [3:0] SYNC_W    = 4'b0000;
    localparam logic [3:0] SYNC_F    = 4'b1111;
    localparam int         NUM_SLOTS = 9;
    localparam int         RATE_W    = 11;
    localparam int         IDX_W     = 4;

    typedef logic [RATE_W-1:0] rate_t;
    typedef logic [IDX_W-1:0]  idx_t;

    localparam idx_t LAST_SLOT = idx_t'(NUM_SLOTS - 1);

    function automatic rate_t rate_of(input logic [1:0] sw);
        case (sw)
            2'd0:    rate_of = rate_t'(500);
            2'd1:    rate_of = rate_t'(750);
            2'd2:    rate_of = rate_t'(1000);
            default: rate_of = rate_t'(1250);
        endcase
    endfunction

endpackage

// File: rtl/dfrx_slot_timer.sv
// Slot timing for the frame receiver: latches RATE at frame start, runs the
// alignment delay, then back-to-back slots of RATE+1 cycles with a mid-slot sample strobe.
module dfrx_slot_timer
    import dfrx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       align_en,
    input  logic       recv_en,
    input  logic [1:0] sw,
    output idx_t       slot_idx,
    output logic       align_done,
    output logic       sample,
    output logic       slot_end
);

    rate_t rate_q, rate_d;
    rate_t cnt_q, cnt_d;
    idx_t  idx_q, idx_d;

    assign slot_idx = idx_q;

    always_comb begin
        rate_d     = rate_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        // Alignment spans RATE+2 cycles, counted 0..RATE+1.
        align_done = align_en && (cnt_q == rate_q + rate_t'(1));
        sample     = recv_en && (cnt_q == (rate_q >> 1));
        slot_end   = recv_en && (cnt_q == rate_q);
        if (start) begin
            rate_d = rate_of(sw);
            cnt_d  = '0;
            idx_d  = '0;
        end else if (align_en) begin
            cnt_d = align_done ? '0 : cnt_q + rate_t'(1);
        end else if (recv_en) begin
            if (slot_end) begin
                cnt_d = '0;
                idx_d = idx_q + idx_t'(1);
            end else begin
                cnt_d = cnt_q + rate_t'(1);
            end
        end else begin
            cnt_d = '0;
            idx_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rate_q <= '0;
            cnt_q  <= '0;
            idx_q  <= '0;
        end else begin
            rate_q <= rate_d;
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
        end
    end

endmodule

// File: rtl/dspace_frame_rx.sv
// Receives a 9-slot nibble frame, checks the sync slots and publishes the data nibbles.
// Optional saturating error counter enabled by defining DFRX_ERRCNT_EN.
module dspace_frame_rx
    import dfrx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sw,
    input  logic       frame_start,
    input  logic [3:0] nib_in,
    output logic [3:0] rx_w1,
    output logic [3:0] rx_w2,
    output logic [3:0] rx_w3,
    output logic [3:0] vhi1,
    output logic [3:0] vhi2,
    output logic [3:0] vhi3,
    output logic       frame_valid,
    output logic       frame_err,
    output logic       busy
`ifdef DFRX_ERRCNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    state_e                        state_q, state_d;
    logic [NUM_SLOTS-1:0][3:0]     cap_q, cap_d;
    logic [5:0][3:0]               out_q, out_d;
    logic                          valid_q, valid_d;
    logic                          err_q, err_d;
    logic                          sync_ok;
    idx_t                          slot_idx;
    logic                          align_done, sample, slot_end;

    dfrx_slot_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .start      (frame_start),
        .align_en   (state_q == ST_ALIGN),
        .recv_en    (state_q == ST_RECV),
        .sw         (sw),
        .slot_idx   (slot_idx),
        .align_done (align_done),
        .sample     (sample),
        .slot_end   (slot_end)
    );

    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        out_d   = out_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        sync_ok = (cap_q[0] == SYNC_W) && (cap_q[7] == SYNC_F) &&
                  (cap_q[NUM_SLOTS-1] == SYNC_F);
        // A new strobe always wins: the transmitter has restarted, so drop the frame silently.
        if (frame_start) begin
            state_d = ST_ALIGN;
            cap_d   = '0;
        end else begin
            case (state_q)
                ST_ALIGN: if (align_done) state_d = ST_RECV;
                ST_RECV: begin
                    if (sample) begin
                        cap_d[slot_idx] = nib_in;
                        if (slot_idx == LAST_SLOT) state_d = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    state_d = ST_IDLE;
                    if (sync_ok) begin
                        out_d   = cap_q[6:1];
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cap_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

`ifdef DFRX_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) err_cnt_q <= '0;
        else     err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`endif

    assign rx_w1       = out_q[0];
    assign rx_w2       = out_q[1];
    assign rx_w3       = out_q[2];
    assign vhi1        = out_q[3];
    assign vhi2        = out_q[4];
    assign vhi3        = out_q[5];
    assign frame_valid = valid_q;
    assign frame_err   = err_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dspace_frame_rx.sv
// Bench for dspace_frame_rx: models the nibble transmitter, queues the expected
// result of each frame and compares it when frame_valid/frame_err fires.
module tb_dspace_frame_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sw;
    logic       frame_start;
    logic [3:0] nib_in;
    logic [3:0] rx_w1, rx_w2, rx_w3, vhi1, vhi2, vhi3;
    logic       frame_valid, frame_err, busy;
`ifdef DFRX_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    dspace_frame_rx dut (
        .clk         (clk),
        .rst         (rst),
        .sw          (sw),
        .frame_start (frame_start),
        .nib_in      (nib_in),
        .rx_w1       (rx_w1),
        .rx_w2       (rx_w2),
        .rx_w3       (rx_w3),
        .vhi1        (vhi1),
        .vhi2        (vhi2),
        .vhi3        (vhi3),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .busy        (busy)
`ifdef DFRX_ERRCNT_EN
        ,
        .err_cnt     (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]      sw;
        logic [8:0][3:0] nib;
        logic            good;
    } vec_t;

    typedef struct packed {
        logic        good;
        logic [23:0] outs;
        logic [7:0]  cnt;
        int          t;
    } exp_t;

    exp_t        q[$];
    vec_t        tbl[6];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [23:0] m_outs;
    logic [7:0]  m_cnt;
    logic [23:0] dut_outs;

    assign dut_outs = {rx_w1, rx_w2, rx_w3, vhi1, vhi2, vhi3};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int rate_for(input logic [1:0] s);
        case (s)
            2'd0:    return 500;
            2'd1:    return 750;
            2'd2:    return 1000;
            default: return 1250;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard consumer: every pulse must match the oldest queued frame.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && (frame_valid || frame_err)) begin
            chk("pulse_exclusive", 32'(frame_valid & frame_err), 32'd0);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: valid=%0b err=%0b with nothing pending (cycle %0d)",
                         frame_valid, frame_err, cyc);
            end else begin
                e = q.pop_front();
                chk("pulse_kind", 32'({frame_valid, frame_err}), e.good ? 32'd2 : 32'd1);
                chk("pulse_time", 32'(cyc), 32'(e.t));
                chk("outputs", 32'(dut_outs), 32'(e.outs));
`ifdef DFRX_ERRCNT_EN
                chk("err_cnt", 32'(err_cnt), 32'(e.cnt));
`endif
            end
        end
    end

    // Transmitter model: cycle 0 carries frame_start; slot k occupies cycles
    // RATE+3+k*(RATE+1) .. +RATE and the true nibble is present only at the
    // mid-slot sample cycle, its complement elsewhere in the slot.
    task automatic drive_frame(input logic [1:0] s, input logic [1:0] s_late,
                               input logic [8:0][3:0] n, input int stop_c,
                               input bit push, input bit good);
        int   r, s8, last, off, k, o;
        exp_t e;
        r    = rate_for(s);
        s8   = r + 3 + 8 * (r + 1) + r / 2;
        last = (stop_c >= 0) ? stop_c : s8;
        for (int c = 0; c <= last; c++) begin
            frame_start = (c == 0);
            sw          = (c == 0) ? s : s_late;
            nib_in      = 4'($urandom);
            if (c >= r + 3) begin
                off = c - (r + 3);
                k   = off / (r + 1);
                o   = off % (r + 1);
                if (k < 9) nib_in = (o == r / 2) ? n[k] : ~n[k];
            end
            if (c == 0 && push) begin
                if (good) m_outs = {n[1], n[2], n[3], n[4], n[5], n[6]};
                else if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
                e.good = good;
                e.outs = m_outs;
                e.cnt  = m_cnt;
                e.t    = cyc + s8 + 2;
                q.push_back(e);
            end
            if (c == 1) chk("busy_after_start", 32'(busy), 32'd1);
            @(negedge clk);
        end
        frame_start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL missing_pulse: %0d frame results still pending (cycle %0d)", q.size(), cyc);
            q.delete();
        end
        chk("busy_after_frame", 32'(busy), 32'd0);
    endtask

    initial begin
        #30_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{sw: 2'd1, nib: 36'hFFCBA9530, good: 1'b1};
        tbl[1] = '{sw: 2'd0, nib: 36'hFE6543210, good: 1'b0};
        tbl[2] = '{sw: 2'd0, nib: 36'hFF0F0F0F0, good: 1'b1};
        tbl[3] = '{sw: 2'd0, nib: 36'hFF1234561, good: 1'b0};
        tbl[4] = '{sw: 2'd2, nib: 36'hFF7E8D9C0, good: 1'b1};
        tbl[5] = '{sw: 2'd0, nib: 36'h7F2222220, good: 1'b0};

        rst = 1'b1; frame_start = 1'b0; sw = 2'd0; nib_in = 4'h0;
        m_outs = '0; m_cnt = '0;
        repeat (3) @(negedge clk);
        chk("reset_outs", 32'(dut_outs), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_pulses", 32'({frame_valid, frame_err}), 32'd0);
`ifdef DFRX_ERRCNT_EN
        chk("reset_err_cnt", 32'(err_cnt), 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Reset beats a simultaneous start strobe.
        rst = 1'b1; frame_start = 1'b1;
        @(negedge clk);
        chk("rst_over_start_busy", 32'(busy), 32'd0);
        rst = 1'b0; frame_start = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            drive_frame(tbl[i].sw, 2'($urandom), tbl[i].nib, -1, 1'b1, tbl[i].good);
            drain();
        end

        // Restart during slot 4: the aborted frame must produce nothing.
        drive_frame(2'd0, 2'd0, 36'h000000000, 503 + 4 * 501 + 100, 1'b0, 1'b0);
        drive_frame(2'd0, 2'd2, 36'hFF1E2D3C0, -1, 1'b1, 1'b1);
        drain();

        // Reset during slot 5 clears outputs and drops the frame.
        drive_frame(2'd0, 2'd0, 36'hFFABCDEF0, 503 + 5 * 501 + 10, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        m_outs = '0; m_cnt = '0;
        chk("midframe_rst_outs", 32'(dut_outs), 32'd0);
        chk("midframe_rst_busy", 32'(busy), 32'd0);
`ifdef DFRX_ERRCNT_EN
        chk("midframe_rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
        rst = 1'b0;
        repeat (5) @(negedge clk);
        drive_frame(2'd0, 2'd1, 36'hFF4567890, -1, 1'b1, 1'b1);
        drain();

        // sw moves 3 -> 0 right after the strobe; spacing must stay at RATE=1250.
        drive_frame(2'd3, 2'd0, 36'hFF6C5B4A0, -1, 1'b1, 1'b1);
        drain();

`ifdef DFRX_ERRCNT_EN
        for (int i = 0; i < 260; i++) begin
            drive_frame(2'd0, 2'($urandom), 36'hFE1111110, -1, 1'b1, 1'b0);
            drain();
        end
        chk("err_cnt_saturated", 32'(err_cnt), 32'd255);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
